mips_multi_ctrl: RTL and testbench

- Parametrised multicycle MIPS control unit: Moore FSM driving every control input of the multicycle datapath (PC, IR, register file, ALU muxes, ALU_control, PC source).
- Adds a memory ready handshake for wait states, a bne path, a per-funct ALU decode, an illegal-opcode flag and a retired-instruction counter.
- Sits beside the datapath; takes Op/Funct from the IR and drives the datapath control pins directly.

---
 rtl/mips_multi_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_mips_multi_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/mips_multi_ctrl.sv
// Multicycle MIPS control unit: Moore FSM with memory wait states, beq/bne,
// R-type funct decode, sticky illegal-opcode flag and retired-instruction count.
module mips_multi_ctrl #(
  parameter int unsigned MEM_HANDSHAKE = 1,
  parameter int unsigned SUPPORT_BNE   = 1,
  parameter int unsigned CNT_W         = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       Op,
  input  logic [5:0]       Funct,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             PC_write,
  output logic             Mem_write,
  output logic             lorD_mux,
  output logic             IR_write,
  output logic             Reg_Dst_mux,
  output logic             Mem_reg_mux,
  output logic             Reg_write,
  output logic             ALU_srcA_mux,
  output logic [1:0]       ALU_srcB_mux,
  output logic [2:0]       ALU_control,
  output logic [1:0]       Pc_src_mux,
  output logic             Branch,
  output logic             Branch_ne,
  output logic             ALU_reg_write,
  output logic             illegal_op,
  output logic [3:0]       state_o,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADR   = 4'd3,
    S_MEMREAD  = 4'd4,
    S_MEMWB    = 4'd5,
    S_MEMWRITE = 4'd6,
    S_EXECUTE  = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_ADDIEX   = 4'd10,
    S_ADDIWB   = 4'd11,
    S_JUMP     = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t           state_q, state_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             retire;
  logic             ready;
  logic             funct_legal;

  assign ready       = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;
  assign funct_legal = (Funct == 6'h20) || (Funct == 6'h22) || (Funct == 6'h24) ||
                       (Funct == 6'h25) || (Funct == 6'h2A);

  always_comb begin
    state_d   = S_IDLE;
    illegal_d = illegal_q;
    retire    = 1'b0;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  state_d = ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        state_d = S_FETCH;
        case (Op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE: begin
            if (funct_legal) state_d = S_EXECUTE;
            else             illegal_d = 1'b1;
          end
          OP_BEQ:  state_d = S_BRANCH;
          OP_BNE: begin
            if (SUPPORT_BNE != 0) state_d = S_BRANCH;
            else                  illegal_d = 1'b1;
          end
          OP_ADDI: state_d = S_ADDIEX;
          OP_J:    state_d = S_JUMP;
          default: illegal_d = 1'b1;
        endcase
      end
      S_MEMADR:  state_d = (Op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD: state_d = ready ? S_MEMWB : S_MEMREAD;
      S_MEMWRITE: begin
        state_d = ready ? S_FETCH : S_MEMWRITE;
        retire  = ready;
      end
      S_EXECUTE: state_d = S_ALUWB;
      S_ADDIEX:  state_d = S_ADDIWB;
      S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    count_d = retire ? count_q + CNT_W'(1) : count_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      illegal_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      count_q   <= count_d;
    end
  end

  // Moore decode; only FETCH (ready), EXECUTE (Funct) and BRANCH (Op) look past the state
  always_comb begin
    mem_req       = 1'b0;
    PC_write      = 1'b0;
    Mem_write     = 1'b0;
    lorD_mux      = 1'b0;
    IR_write      = 1'b0;
    Reg_Dst_mux   = 1'b0;
    Mem_reg_mux   = 1'b0;
    Reg_write     = 1'b0;
    ALU_srcA_mux  = 1'b0;
    ALU_srcB_mux  = 2'b00;
    ALU_control   = 3'b000;
    Pc_src_mux    = 2'b00;
    Branch        = 1'b0;
    Branch_ne     = 1'b0;
    ALU_reg_write = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req      = 1'b1;
        ALU_srcB_mux = 2'b01;
        ALU_control  = ALU_ADD;
        IR_write     = ready;
        PC_write     = ready;
      end
      S_DECODE: begin
        ALU_srcB_mux  = 2'b11;
        ALU_control   = ALU_ADD;
        ALU_reg_write = 1'b1;
      end
      S_MEMADR, S_ADDIEX: begin
        ALU_srcA_mux  = 1'b1;
        ALU_srcB_mux  = 2'b10;
        ALU_control   = ALU_ADD;
        ALU_reg_write = 1'b1;
      end
      S_MEMREAD: begin
        mem_req  = 1'b1;
        lorD_mux = 1'b1;
      end
      S_MEMWB: begin
        Mem_reg_mux = 1'b1;
        Reg_write   = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req   = 1'b1;
        lorD_mux  = 1'b1;
        Mem_write = 1'b1;
      end
      S_EXECUTE: begin
        ALU_srcA_mux  = 1'b1;
        ALU_reg_write = 1'b1;
        case (Funct)
          6'h20:   ALU_control = ALU_ADD;
          6'h22:   ALU_control = ALU_SUB;
          6'h24:   ALU_control = ALU_AND;
          6'h25:   ALU_control = ALU_OR;
          6'h2A:   ALU_control = ALU_SLT;
          default: ALU_control = 3'b000;
        endcase
      end
      S_ALUWB: begin
        Reg_Dst_mux = 1'b1;
        Reg_write   = 1'b1;
      end
      S_BRANCH: begin
        ALU_srcA_mux = 1'b1;
        ALU_control  = ALU_SUB;
        Pc_src_mux   = 2'b01;
        Branch       = (Op == OP_BEQ);
        Branch_ne    = (Op == OP_BNE) && (SUPPORT_BNE != 0);
      end
      S_ADDIWB: Reg_write = 1'b1;
      S_JUMP: begin
        Pc_src_mux = 2'b10;
        PC_write   = 1'b1;
      end
      default: ;
    endcase
  end

  assign illegal_op  = illegal_q;
  assign state_o     = state_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_mips_multi_ctrl.sv
// Bench for mips_multi_ctrl: four instances (default, no bne, 4-bit counter,
// no handshake) driven from shared inputs; table vectors plus corner sequences.
module tb_mips_multi_ctrl;

  typedef struct packed {
    logic       mem_req, pc_write, mem_write, lord, ir_write, reg_dst, mem_reg, reg_write, srca;
    logic [1:0] srcb;
    logic [2:0] alu;
    logic [1:0] pcsrc;
    logic       br, bne, arw, ill;
    logic [3:0] st;
  } outs_t;

  // Packed output vectors per state, field order as outs_t
  localparam logic [23:0] O_IDLE  = 24'b0_0_0_0_0_0_0_0_0_00_000_00_0_0_0_0_0000;
  localparam logic [23:0] O_FE_R  = 24'b1_1_0_0_1_0_0_0_0_01_010_00_0_0_0_0_0001;
  localparam logic [23:0] O_FE_W  = 24'b1_0_0_0_0_0_0_0_0_01_010_00_0_0_0_0_0001;
  localparam logic [23:0] O_DEC   = 24'b0_0_0_0_0_0_0_0_0_11_010_00_0_0_1_0_0010;
  localparam logic [23:0] O_MADR  = 24'b0_0_0_0_0_0_0_0_1_10_010_00_0_0_1_0_0011;
  localparam logic [23:0] O_MRD   = 24'b1_0_0_1_0_0_0_0_0_00_000_00_0_0_0_0_0100;
  localparam logic [23:0] O_MWB   = 24'b0_0_0_0_0_0_1_1_0_00_000_00_0_0_0_0_0101;
  localparam logic [23:0] O_MWR   = 24'b1_0_1_1_0_0_0_0_0_00_000_00_0_0_0_0_0110;
  localparam logic [23:0] O_EXADD = 24'b0_0_0_0_0_0_0_0_1_00_010_00_0_0_1_0_0111;
  localparam logic [23:0] O_EXSUB = 24'b0_0_0_0_0_0_0_0_1_00_110_00_0_0_1_0_0111;
  localparam logic [23:0] O_EXAND = 24'b0_0_0_0_0_0_0_0_1_00_000_00_0_0_1_0_0111;
  localparam logic [23:0] O_EXOR  = 24'b0_0_0_0_0_0_0_0_1_00_001_00_0_0_1_0_0111;
  localparam logic [23:0] O_EXSLT = 24'b0_0_0_0_0_0_0_0_1_00_111_00_0_0_1_0_0111;
  localparam logic [23:0] O_AWB   = 24'b0_0_0_0_0_1_0_1_0_00_000_00_0_0_0_0_1000;
  localparam logic [23:0] O_BEQ   = 24'b0_0_0_0_0_0_0_0_1_00_110_01_1_0_0_0_1001;
  localparam logic [23:0] O_BNE   = 24'b0_0_0_0_0_0_0_0_1_00_110_01_0_1_0_0_1001;
  localparam logic [23:0] O_AIEX  = 24'b0_0_0_0_0_0_0_0_1_10_010_00_0_0_1_0_1010;
  localparam logic [23:0] O_AIWB  = 24'b0_0_0_0_0_0_0_1_0_00_000_00_0_0_0_0_1011;
  localparam logic [23:0] O_JMP   = 24'b0_1_0_0_0_0_0_0_0_00_000_10_0_0_0_0_1100;
  localparam logic [23:0] ILL     = 24'h000010;

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        rdy;
    logic [23:0] exp;
    logic [31:0] cnt;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [5:0]  op = 6'h00;
  logic [5:0]  fn = 6'h00;
  logic        rdy = 1'b0;
  outs_t       o_w [4];
  logic [31:0] cnt_w [4];
  int          checks = 0;
  int          errors = 0;
  vec_t        tv[$];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 4; gi++) begin : g_dut
    localparam int unsigned HS = (gi == 3) ? 0 : 1;
    localparam int unsigned SB = (gi == 1) ? 0 : 1;
    localparam int unsigned CW = (gi == 2) ? 4 : 32;
    logic          mem_req, pc_write, mem_write, lord, ir_write, reg_dst, mem_reg, reg_write;
    logic          srca, br, bne, arw, ill;
    logic [1:0]    srcb, pcsrc;
    logic [2:0]    alu;
    logic [3:0]    st;
    logic [CW-1:0] cnt;
    mips_multi_ctrl #(.MEM_HANDSHAKE(HS), .SUPPORT_BNE(SB), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset), .Op(op), .Funct(fn), .mem_ready(rdy),
      .mem_req(mem_req), .PC_write(pc_write), .Mem_write(mem_write), .lorD_mux(lord),
      .IR_write(ir_write), .Reg_Dst_mux(reg_dst), .Mem_reg_mux(mem_reg), .Reg_write(reg_write),
      .ALU_srcA_mux(srca), .ALU_srcB_mux(srcb), .ALU_control(alu), .Pc_src_mux(pcsrc),
      .Branch(br), .Branch_ne(bne), .ALU_reg_write(arw), .illegal_op(ill),
      .state_o(st), .instr_count(cnt)
    );
    assign o_w[gi]   = {mem_req, pc_write, mem_write, lord, ir_write, reg_dst, mem_reg, reg_write,
                        srca, srcb, alu, pcsrc, br, bne, arw, ill, st};
    assign cnt_w[gi] = 32'(cnt);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic [5:0] o, input logic [5:0] f, input logic r,
                     input logic [23:0] e, input logic [31:0] c);
    tv.push_back('{op: o, fn: f, rdy: r, exp: e, cnt: c});
  endtask

  initial begin
    // add
    add(6'h00, 6'h20, 1, O_IDLE, 0);  add(6'h00, 6'h20, 1, O_FE_R, 0);
    add(6'h00, 6'h20, 0, O_DEC, 0);   add(6'h00, 6'h20, 0, O_EXADD, 0);
    add(6'h00, 6'h20, 0, O_AWB, 0);
    // lw: one fetch wait, three read waits
    add(6'h23, 6'h00, 0, O_FE_W, 1);  add(6'h23, 6'h00, 1, O_FE_R, 1);
    add(6'h23, 6'h00, 0, O_DEC, 1);   add(6'h23, 6'h00, 0, O_MADR, 1);
    add(6'h23, 6'h00, 0, O_MRD, 1);   add(6'h23, 6'h00, 0, O_MRD, 1);
    add(6'h23, 6'h00, 0, O_MRD, 1);   add(6'h23, 6'h00, 1, O_MRD, 1);
    add(6'h23, 6'h00, 0, O_MWB, 1);
    // sw: two write waits
    add(6'h2B, 6'h00, 1, O_FE_R, 2);  add(6'h2B, 6'h00, 1, O_DEC, 2);
    add(6'h2B, 6'h00, 1, O_MADR, 2);  add(6'h2B, 6'h00, 0, O_MWR, 2);
    add(6'h2B, 6'h00, 0, O_MWR, 2);   add(6'h2B, 6'h00, 1, O_MWR, 2);
    // beq, bne
    add(6'h04, 6'h00, 1, O_FE_R, 3);  add(6'h04, 6'h00, 1, O_DEC, 3);
    add(6'h04, 6'h00, 1, O_BEQ, 3);
    add(6'h05, 6'h00, 1, O_FE_R, 4);  add(6'h05, 6'h00, 1, O_DEC, 4);
    add(6'h05, 6'h00, 1, O_BNE, 4);
    // sub, and, or, slt
    add(6'h00, 6'h22, 1, O_FE_R, 5);  add(6'h00, 6'h22, 1, O_DEC, 5);
    add(6'h00, 6'h22, 1, O_EXSUB, 5); add(6'h00, 6'h22, 1, O_AWB, 5);
    add(6'h00, 6'h24, 1, O_FE_R, 6);  add(6'h00, 6'h24, 1, O_DEC, 6);
    add(6'h00, 6'h24, 1, O_EXAND, 6); add(6'h00, 6'h24, 1, O_AWB, 6);
    add(6'h00, 6'h25, 1, O_FE_R, 7);  add(6'h00, 6'h25, 1, O_DEC, 7);
    add(6'h00, 6'h25, 1, O_EXOR, 7);  add(6'h00, 6'h25, 1, O_AWB, 7);
    add(6'h00, 6'h2A, 1, O_FE_R, 8);  add(6'h00, 6'h2A, 1, O_DEC, 8);
    add(6'h00, 6'h2A, 1, O_EXSLT, 8); add(6'h00, 6'h2A, 1, O_AWB, 8);
    // addi, j
    add(6'h08, 6'h00, 1, O_FE_R, 9);  add(6'h08, 6'h00, 1, O_DEC, 9);
    add(6'h08, 6'h00, 1, O_AIEX, 9);  add(6'h08, 6'h00, 1, O_AIWB, 9);
    add(6'h02, 6'h00, 1, O_FE_R, 10); add(6'h02, 6'h00, 1, O_DEC, 10);
    add(6'h02, 6'h00, 1, O_JMP, 10);
    // illegal opcode, illegal funct, then j with sticky flag
    add(6'h3F, 6'h00, 1, O_FE_R, 11);       add(6'h3F, 6'h00, 1, O_DEC, 11);
    add(6'h00, 6'h03, 1, O_FE_R | ILL, 11); add(6'h00, 6'h03, 1, O_DEC | ILL, 11);
    add(6'h02, 6'h00, 1, O_FE_R | ILL, 11); add(6'h02, 6'h00, 1, O_DEC | ILL, 11);
    add(6'h02, 6'h00, 1, O_JMP | ILL, 11);
    add(6'h00, 6'h20, 1, O_FE_R | ILL, 12);

    // Reset state
    reset = 1'b1;
    tick();
    tick();
    chk("reset_outs", 32'(o_w[0]), 32'(O_IDLE));
    chk("reset_cnt", cnt_w[0], 0);
    reset = 1'b0;

    foreach (tv[i]) begin
      op  = tv[i].op;
      fn  = tv[i].fn;
      rdy = tv[i].rdy;
      #1;
      $display("vec %0d op=%h fn=%h rdy=%0d state=%0d outs=%h cnt=%0d",
               i, op, fn, rdy, o_w[0].st, o_w[0], cnt_w[0]);
      chk($sformatf("vec%0d_outs", i), 32'(o_w[0]), 32'(tv[i].exp));
      chk($sformatf("vec%0d_cnt", i), cnt_w[0], tv[i].cnt);
      tick();
    end

    // bne with and without SUPPORT_BNE
    reset = 1'b1;
    tick();
    reset = 1'b0;
    op = 6'h05; fn = 6'h00; rdy = 1'b1;
    tick(); tick(); tick();
    $display("bne: dut0 state=%0d dut1 state=%0d ill=%0d", o_w[0].st, o_w[1].st, o_w[1].ill);
    chk("bne_on_outs", 32'(o_w[0]), 32'(O_BNE));
    chk("bne_off_outs", 32'(o_w[1]), 32'(O_FE_R | ILL));
    tick(); tick();
    chk("bne_off_cnt", cnt_w[1], 0);
    chk("bne_on_cnt", cnt_w[0], 1);

    // 17 addi with a 4-bit counter
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_clears_ill", 32'(o_w[1]), 32'(O_IDLE));
    op = 6'h08; rdy = 1'b1;
    tick();
    for (int k = 0; k < 17 * 4; k++) tick();
    $display("addi x17: cnt4=%0d cnt32=%0d state=%0d", cnt_w[2], cnt_w[0], o_w[2].st);
    chk("wrap_cnt4", cnt_w[2], 1);
    chk("wrap_state", 32'(o_w[2].st), 1);
    chk("nowrap_cnt32", cnt_w[0], 17);

    // Reset while waiting in MEMREAD
    op = 6'h23;
    tick(); tick(); tick();
    rdy = 1'b0;
    tick();
    chk("memrd_wait", 32'(o_w[0]), 32'(O_MRD));
    reset = 1'b1;
    tick();
    $display("reset in memread: state=%0d outs=%h cnt=%0d", o_w[0].st, o_w[0], cnt_w[0]);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("abort%0d_outs", k), 32'(o_w[k]), 32'(O_IDLE));
      chk($sformatf("abort%0d_cnt", k), cnt_w[k], 0);
    end

    // No handshake: lw completes with mem_ready held low
    reset = 1'b0;
    op = 6'h23; rdy = 1'b0;
    tick();
    chk("nohs_fetch", 32'(o_w[3]), 32'(O_FE_R));
    chk("hs_fetch_wait", 32'(o_w[0]), 32'(O_FE_W));
    for (int k = 2; k <= 5; k++) begin
      tick();
      chk($sformatf("nohs_state%0d", k), 32'(o_w[3].st), k);
    end
    tick();
    $display("nohs lw: state=%0d cnt=%0d", o_w[3].st, cnt_w[3]);
    chk("nohs_back_fetch", 32'(o_w[3].st), 1);
    chk("nohs_cnt", cnt_w[3], 1);
    chk("hs_still_fetch", 32'(o_w[0].st), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
